// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq -- sequential ALU with a valid/ready request side and a
// valid/ready result side.
//
// Single-cycle operations: AND, OR, NOR, ADD, SUB, SLT, SLTU, SLL, SRL, SRA.
// A result appears one cycle after the request is accepted.
//
// Optional multi-cycle MUL (low WIDTH bits of a*b), built as an iterative
// shift-add that handles one multiplier bit per cycle. It is enabled only
// when the macro ALU_SEQ_MUL_EN is defined. Without the macro there is no
// multiplier logic and no BUSY state, and opcode 0111 is an illegal opcode.
//
// Handshake (both sides): a transfer happens on a rising clk edge where
// valid && ready are both high. The producer keeps valid high and its
// payload stable until that edge. Here in_ready is high only in IDLE.
// out_valid is high only in DONE, and result/zero/lt/err are held there
// until the edge that sees out_ready high.
//
// Ports
//   clk          in   clock; all state changes on the rising edge
//   reset        in   synchronous, active-high
//   in_valid     in   request present
//   in_ready     out  request can be accepted this cycle
//   op           in   4-bit opcode
//   a, b         in   WIDTH-bit operands, captured on acceptance
//   out_valid    out  result and flags are valid
//   out_ready    in   consumer takes the result this cycle
//   result       out  WIDTH-bit result
//   zero         out  result == 0
//   lt           out  signed(a) < signed(b) for the captured operands
//   err          out  illegal opcode
//   dbg_state_o  out  current FSM state (0 IDLE, 1 BUSY, 2 DONE)
// ---------------------------------------------------------------------------
module alu_seq #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             lt,
  output logic             err,
  output logic [1:0]       dbg_state_o
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SLL  = 4'b0011;
  localparam logic [3:0] OP_SRL  = 4'b0100;
  localparam logic [3:0] OP_SRA  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;
  localparam logic [3:0] OP_NOR  = 4'b1100;

`ifdef ALU_SEQ_MUL_EN
  localparam logic [3:0] OP_MUL  = 4'b0111;
  // One extra bit so the counter can reach WIDTH without wrapping.
  localparam int CW = SHW + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DONE = 2'd2
  } state_t;
`endif

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             lt_q, lt_d;
  logic             err_q, err_d;

`ifdef ALU_SEQ_MUL_EN
  logic [WIDTH-1:0] mcand_q, mcand_d;   // multiplicand, shifted left each step
  logic [WIDTH-1:0] mplier_q, mplier_d; // multiplier, shifted right each step
  logic [WIDTH-1:0] acc_q, acc_d;       // partial product
  logic [CW-1:0]    cnt_q, cnt_d;       // completed iterations
  logic [WIDTH-1:0] acc_sum;
`endif

  // -------------------------------------------------------------------------
  // Combinational single-cycle datapath, fed straight from the request port
  // so the result can be registered on the acceptance edge.
  // -------------------------------------------------------------------------
  logic [SHW-1:0]   shamt;
  logic             slt_s;
  logic             slt_u;
  logic [WIDTH-1:0] alu_res;
  logic             alu_err;
  logic             is_mul;

  assign shamt = b[SHW-1:0];
  assign slt_s = $signed(a) < $signed(b);
  assign slt_u = a < b;

`ifdef ALU_SEQ_MUL_EN
  assign is_mul = (op == OP_MUL);
`else
  assign is_mul = 1'b0;
`endif

  always_comb begin
    alu_res = '0;
    alu_err = 1'b0;
    case (op)
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_NOR:  alu_res = ~(a | b);
      OP_ADD:  alu_res = a + b;
      OP_SUB:  alu_res = a - b;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, slt_s};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, slt_u};
      OP_SLL:  alu_res = a << shamt;
      OP_SRL:  alu_res = a >> shamt;
      OP_SRA:  alu_res = $signed(a) >>> shamt;
`ifdef ALU_SEQ_MUL_EN
      // Produced by the iterative path; nothing to compute here.
      OP_MUL:  alu_res = '0;
`endif
      default: alu_err = 1'b1;
    endcase
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    zero_d   = zero_q;
    lt_d     = lt_q;
    err_d    = err_q;
`ifdef ALU_SEQ_MUL_EN
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    acc_sum  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          // lt always reflects the captured operands, whatever the opcode.
          lt_d = slt_s;
          if (is_mul) begin
`ifdef ALU_SEQ_MUL_EN
            state_d  = S_BUSY;
            err_d    = 1'b0;
            zero_d   = 1'b0;
            mcand_d  = a;
            mplier_d = b;
            acc_d    = '0;
            cnt_d    = '0;
`endif
          end else begin
            state_d  = S_DONE;
            result_d = alu_res;
            zero_d   = (alu_res == '0);
            err_d    = alu_err;
          end
        end
      end

`ifdef ALU_SEQ_MUL_EN
      S_BUSY: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        // The edge that performs the last iteration also loads the result.
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d  = S_DONE;
          result_d = acc_sum;
          zero_d   = (acc_sum == '0);
        end
      end
`endif

      S_DONE: begin
        // The consuming edge returns to IDLE only; a new request can be
        // accepted on the following edge at the earliest.
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // State register; reset wins over acceptance and consumption.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      zero_q   <= 1'b0;
      lt_q     <= 1'b0;
      err_q    <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      lt_q     <= lt_d;
      err_q    <= err_d;
`ifdef ALU_SEQ_MUL_EN
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
`endif
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign in_ready    = (state_q == S_IDLE);
  assign out_valid   = (state_q == S_DONE);
  assign result      = result_q;
  assign zero        = zero_q;
  assign lt          = lt_q;
  assign err         = err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_alu_seq.sv
`timescale 1ns/1ps
// Testbench for alu_seq: a WIDTH=64 instance for the main vector table and
// sequences, plus a WIDTH=8 instance for the narrow-width cases.
module tb_alu_seq;

  localparam int W = 64;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic          in_valid, in_valid8, out_ready, out_ready8;
  logic [3:0]    op;
  logic [W-1:0]  a, b;

  logic          in_ready, out_valid, zero, lt, err;
  logic [W-1:0]  result;
  logic [1:0]    dbg_state;

  logic          in_ready8, out_valid8, zero8, lt8, err8;
  logic [7:0]    result8;
  logic [1:0]    dbg_state8;

  alu_seq #(.WIDTH(W)) u_dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .lt(lt), .err(err),
    .dbg_state_o(dbg_state)
  );

  alu_seq #(.WIDTH(8)) u_dut8 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid8), .in_ready(in_ready8),
    .op(op), .a(a[7:0]), .b(b[7:0]),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .result(result8), .zero(zero8), .lt(lt8), .err(err8),
    .dbg_state_o(dbg_state8)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Present one request, garble the inputs right after acceptance, then wait
  // (bounded) for out_valid. lat counts rising edges from acceptance
  // (inclusive) until out_valid is seen. Returns at a falling edge with the
  // result still pending.
  task automatic run_op(input bit w8, input logic [3:0] o,
                        input logic [W-1:0] av, input logic [W-1:0] bv,
                        output logic [W-1:0] r, output logic z, output logic l,
                        output logic e, output int lat, output bit busy_ready);
    @(negedge clk);
    op = o; a = av; b = bv;
    if (w8) in_valid8 = 1'b1; else in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_valid8 = 1'b0;
    op = 4'($urandom); a = {$urandom, $urandom}; b = {$urandom, $urandom};
    busy_ready = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!(w8 ? out_valid8 : out_valid) && lat < 300) begin
      if ((w8 ? in_ready8 : in_ready) !== 1'b0) busy_ready = 1'b1;
      @(negedge clk);
      lat++;
    end
    r = w8 ? {56'b0, result8} : result;
    z = w8 ? zero8 : zero;
    l = w8 ? lt8 : lt;
    e = w8 ? err8 : err;
  endtask

  // Take the pending result; after the consuming edge the block is idle.
  task automatic consume(input bit w8, input string nm);
    if (w8) out_ready8 = 1'b1; else out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0; out_ready8 = 1'b0;
    @(negedge clk);
    check({nm, "_ready_after"}, {63'b0, w8 ? in_ready8 : in_ready}, 64'd1);
    check({nm, "_valid_after"}, {63'b0, w8 ? out_valid8 : out_valid}, 64'd0);
  endtask

  // Full directed check of one operation.
  task automatic op_check(input bit w8, input string nm, input logic [3:0] o,
                          input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic [W-1:0] er, input logic ez, input logic el,
                          input logic ee, input int elat);
    logic [W-1:0] r;
    logic z, l, e;
    int lat;
    bit busy_ready;
    exp_q.push_back(er);
    run_op(w8, o, av, bv, r, z, l, e, lat, busy_ready);
    check({nm, "_result"}, r, exp_q.pop_front());
    check({nm, "_zero"}, {63'b0, z}, {63'b0, ez});
    check({nm, "_lt"},   {63'b0, l}, {63'b0, el});
    check({nm, "_err"},  {63'b0, e}, {63'b0, ee});
    check({nm, "_latency"}, 64'(lat), 64'(elat));
    check({nm, "_ready_while_busy"}, {63'b0, busy_ready}, 64'd0);
    consume(w8, nm);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         z;
    logic         l;
    logic         e;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs[NV];

  localparam logic [W-1:0] ONES = {W{1'b1}};
  localparam logic [W-1:0] MSB  = {1'b1, {(W-1){1'b0}}};

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main test ----------------
  initial begin
    bit never_valid;

    //            op       a                        b                        result                   z     l     e
    vecs[0]  = '{4'b0010, ONES,                    64'd1,                   64'd0,                   1'b1, 1'b1, 1'b0};
    vecs[1]  = '{4'b0010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1,                   MSB,                     1'b0, 1'b0, 1'b0};
    vecs[2]  = '{4'b0110, 64'd5,                   64'd7,                   64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{4'b0110, 64'd7,                   64'd7,                   64'd0,                   1'b1, 1'b0, 1'b0};
    vecs[4]  = '{4'b0000, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 64'hF000_F000_F000_F000, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{4'b0001, 64'h0000_0000_1234_0000, 64'h0000_0000_0000_5678, 64'h0000_0000_1234_5678, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{4'b1100, 64'd0,                   64'd0,                   ONES,                    1'b0, 1'b0, 1'b0};
    vecs[7]  = '{4'b1100, ONES,                    64'd0,                   64'd0,                   1'b1, 1'b1, 1'b0};
    vecs[8]  = '{4'b1000, ONES,                    64'd1,                   64'd1,                   1'b0, 1'b1, 1'b0};
    vecs[9]  = '{4'b1001, ONES,                    64'd1,                   64'd0,                   1'b1, 1'b1, 1'b0};
    vecs[10] = '{4'b1000, 64'd1,                   ONES,                    64'd0,                   1'b1, 1'b0, 1'b0};
    vecs[11] = '{4'b1001, 64'd1,                   ONES,                    64'd1,                   1'b0, 1'b0, 1'b0};
    vecs[12] = '{4'b0011, 64'd1,                   64'd63,                  MSB,                     1'b0, 1'b1, 1'b0};
    vecs[13] = '{4'b0011, 64'd1,                   64'h40,                  64'd1,                   1'b0, 1'b1, 1'b0};
    vecs[14] = '{4'b0100, MSB,                     64'd63,                  64'd1,                   1'b0, 1'b1, 1'b0};
    vecs[15] = '{4'b0101, MSB,                     64'd63,                  ONES,                    1'b0, 1'b1, 1'b0};
    vecs[16] = '{4'b0101, 64'h4000_0000_0000_0000, 64'h7E,                  64'd1,                   1'b0, 1'b0, 1'b0};
    vecs[17] = '{4'b0100, 64'h10,                  64'h105,                 64'd0,                   1'b1, 1'b1, 1'b0};
    vecs[18] = '{4'b1111, 64'd1,                   64'd2,                   64'd0,                   1'b1, 1'b1, 1'b1};
    vecs[19] = '{4'b1010, 64'd2,                   64'd1,                   64'd0,                   1'b1, 1'b0, 1'b1};
    vecs[20] = '{4'b1101, 64'd0,                   64'd0,                   64'd0,                   1'b1, 1'b0, 1'b1};

    reset = 1'b1;
    in_valid = 1'b0; in_valid8 = 1'b0;
    out_ready = 1'b0; out_ready8 = 1'b0;
    op = 4'd0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_in_ready",  {63'b0, in_ready},  64'd1);
    check("rst_out_valid", {63'b0, out_valid}, 64'd0);
    check("rst_result",    result,             64'd0);
    check("rst_flags",     {61'b0, zero, lt, err}, 64'd0);
    check("rst_in_ready8", {63'b0, in_ready8}, 64'd1);

    // Table of single-cycle operations
    for (int i = 0; i < NV; i++) begin
      op_check(1'b0, $sformatf("v%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
               vecs[i].res, vecs[i].z, vecs[i].l, vecs[i].e, 1);
    end

    // Opcode 0111: multiply when enabled, illegal otherwise
`ifdef ALU_SEQ_MUL_EN
    op_check(1'b0, "mul64", 4'b0111, 64'd12345, ONES,
             64'hFFFF_FFFF_FFFF_CFC7, 1'b0, 1'b0, 1'b0, W + 1);
    op_check(1'b0, "mul64_b", 4'b0111, 64'h1_0000_0001, 64'h1_0000_0003,
             64'h0000_0004_0000_0003, 1'b0, 1'b1, 1'b0, W + 1);
`else
    op_check(1'b0, "op7_64", 4'b0111, 64'd3, 64'd4, 64'd0, 1'b1, 1'b1, 1'b1, 1);
`endif

    // Narrow instance
    op_check(1'b1, "w8_illegal", 4'b1111, 64'h5, 64'h3, 64'd0, 1'b1, 1'b0, 1'b1, 1);
    op_check(1'b1, "w8_add_wrap", 4'b0010, 64'hFF, 64'h01, 64'd0, 1'b1, 1'b1, 1'b0, 1);
    op_check(1'b1, "w8_sra", 4'b0101, 64'h80, 64'hF9, 64'hC0, 1'b0, 1'b1, 1'b0, 1);
`ifdef ALU_SEQ_MUL_EN
    op_check(1'b1, "w8_mul", 4'b0111, 64'd3, 64'd4, 64'd12, 1'b0, 1'b1, 1'b0, 9);
`else
    op_check(1'b1, "w8_op7", 4'b0111, 64'd3, 64'd4, 64'd0, 1'b1, 1'b1, 1'b1, 1);
`endif

    // Hold with out_ready low; request held high in DONE must be ignored,
    // and must not be taken on the consuming edge either.
    begin
      logic [W-1:0] r;
      logic z, l, e;
      int lat;
      bit busy_ready;
      run_op(1'b0, 4'b0010, 64'd2, 64'd3, r, z, l, e, lat, busy_ready);
      check("hold_first", r, 64'd5);
      in_valid = 1'b1; op = 4'b0010; a = 64'd100; b = 64'd1;
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        check($sformatf("hold%0d_valid", k), {63'b0, out_valid}, 64'd1);
        check($sformatf("hold%0d_ready", k), {63'b0, in_ready}, 64'd0);
        check($sformatf("hold%0d_result", k), result, 64'd5);
        check($sformatf("hold%0d_flags", k), {61'b0, zero, lt, err}, 64'd2);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      @(negedge clk);
      check("hold_idle_valid", {63'b0, out_valid}, 64'd0);
      check("hold_idle_ready", {63'b0, in_ready}, 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      check("hold_next_valid", {63'b0, out_valid}, 64'd1);
      check("hold_next_result", result, 64'd101);
      consume(1'b0, "hold_next");
    end

    // Reset beats acceptance in the same cycle
    @(negedge clk);
    in_valid = 1'b1; op = 4'b0010; a = 64'd1; b = 64'd1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("rprio_valid", {63'b0, out_valid}, 64'd0);
    check("rprio_ready", {63'b0, in_ready}, 64'd1);
    check("rprio_result", result, 64'd0);

    // Abort of an operation in flight
    @(negedge clk);
`ifdef ALU_SEQ_MUL_EN
    in_valid = 1'b1; op = 4'b0111; a = 64'd12345; b = ONES;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
`else
    in_valid = 1'b1; op = 4'b0010; a = 64'd5; b = 64'd5;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
`endif
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("abort_ready", {63'b0, in_ready}, 64'd1);
    check("abort_result", result, 64'd0);
    check("abort_flags", {61'b0, zero, lt, err}, 64'd0);
    never_valid = 1'b1;
    for (int k = 0; k < W + 10; k++) begin
      if (out_valid !== 1'b0) never_valid = 1'b0;
      @(negedge clk);
    end
    check("abort_no_result", {63'b0, never_valid}, 64'd1);

    // Normal operation afterwards
    op_check(1'b0, "post_abort", 4'b0000, 64'hFF, 64'h0F, 64'h0F, 1'b0, 1'b0, 1'b0, 1);

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 64, operand and result width in bits; legal range 8..128.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset sampled on rising edge of clk.
REQ-004 in_valid  input  1  operation request presented.
REQ-005 in_ready  output  1  block accepts a request this cycle.
REQ-006 op  input  4  operation code, see REQ-012.
REQ-007 a, b  input  WIDTH  operands.
REQ-008 out_valid  output  1  result, zero, lt and err valid.
REQ-009 out_ready  input  1  consumer takes the result this cycle.
REQ-010 result  output  WIDTH  operation result; zero / lt / err  output  1 each  flags.

Function
REQ-011 Request accepted on a rising edge when in_valid && in_ready; a, b and op are captured then and are not sampled again.
REQ-012 Opcodes: 0000 AND; 0001 OR; 0010 ADD; 0110 SUB; 1100 NOR; 1000 SLT (signed, result 1/0); 1001 SLTU (unsigned); 0011 SLL; 0100 SRL; 0101 SRA; 0111 MUL (low WIDTH bits of a*b).
REQ-013 ADD/SUB wrap modulo 2^WIDTH; no overflow output.
REQ-014 Shifts use b[clog2(WIDTH)-1:0] as amount; upper bits of b ignored; SRA replicates a[WIDTH-1].
REQ-015 Any other opcode: result = 0, err = 1, completes as single-cycle op.
REQ-016 zero = (result == 0) for every opcode; lt = signed(a) < signed(b) of captured operands, for every opcode.
REQ-017 FSM states IDLE, BUSY, DONE; in_ready = 1 only in IDLE.
REQ-018 IDLE -> DONE on acceptance of any non-MUL op; result registered at that edge; out_valid high the cycle after acceptance (latency 1).
REQ-019 IDLE -> BUSY on acceptance of MUL; iterative shift-add, one multiplier bit per cycle, WIDTH cycles in BUSY; BUSY -> DONE on the edge completing the last iteration; out_valid first high WIDTH+1 cycles after acceptance edge.
REQ-020 DONE: result and flags held stable while out_valid && !out_ready; DONE -> IDLE on edge with out_ready = 1.
REQ-021 No new request accepted in the cycle a result is consumed; next acceptance earliest one cycle later (throughput 1 op per 2 cycles minimum).
REQ-022 in_valid ignored in BUSY and DONE; op/a/b changes there have no effect.
REQ-023 Iteration counter width clog2(WIDTH)+1; no wrap beyond WIDTH.

Reset
REQ-024 reset high on an edge: state = IDLE, out_valid = 0, result = 0, zero = 0, lt = 0, err = 0, counter = 0, multiplier accumulators = 0.
REQ-025 reset asserted in BUSY or DONE aborts the operation; no result is delivered; in_ready = 1 the cycle after reset deasserts.
REQ-026 reset takes priority over acceptance and consumption in the same cycle.

Configuration
REQ-027 Macro ALU_SEQ_MUL_EN defined: MUL implemented per REQ-019.
REQ-028 Macro ALU_SEQ_MUL_EN undefined: no multiplier logic and no BUSY state; opcode 0111 treated per REQ-015 (result 0, err 1, latency 1).

Verification
REQ-029 WIDTH=64, ADD a=0xFFFF_FFFF_FFFF_FFFF, b=1 -> result 0, zero 1, out_valid one cycle after acceptance.
REQ-030 WIDTH=64, SLT a=-1, b=1 -> result 1, lt 1, zero 0; SLTU same operands -> result 0, zero 1, lt 1.
REQ-031 WIDTH=64 with ALU_SEQ_MUL_EN, MUL a=12345, b=-1 -> result -12345 (low 64 bits), out_valid first high 65 cycles after acceptance, in_ready 0 throughout.
REQ-032 Any op completed with out_ready held 0 for 5 cycles -> result/flags stable, in_ready 0; out_ready 1 -> IDLE next edge, in_ready 1.
REQ-033 MUL accepted, reset pulsed 10 cycles later -> out_valid never asserts, all outputs 0, in_ready 1 after reset release.
REQ-034 WIDTH=8, op 1111 -> result 0, err 1, zero 1; without ALU_SEQ_MUL_EN, op 0111 a=3 b=4 -> result 0, err 1, latency 1.
